// File: rtl/freq_meter_pkg.sv
// freq_meter shared definitions: FSM state encoding and the gate-counter
// sizing check used by the top level.
// Optional feature macro (consumed in edge_rise_det): FREQ_METER_SYNC_EN.

package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// True when the gate window is non-empty and GATE_CYCLES-1 fits in a
// gw-bit down-counter (2^gw > gc).
`ifndef FREQ_METER_GATE_W_FITS
`define FREQ_METER_GATE_W_FITS(gc, gw) (((gc) >= 1) && (64'(gc) < (64'd1 << (gw))))
`endif

// File: rtl/freq_meter_if.sv
// Measurement handshake between a requester (master) and freq_meter (slave):
// start request, busy/done status and the held result.

interface freq_meter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edge_count;
    logic             overflow;

    modport master (
        output start,
        input  busy,
        input  done,
        input  edge_count,
        input  overflow
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output edge_count,
        output overflow
    );
endinterface

// File: rtl/edge_rise_det.sv
// Rising-edge detector for the signal under test. sig_in is treated as data.
// With FREQ_METER_SYNC_EN defined, sig_in first crosses a 2-flop synchronizer
// so asynchronous sources are allowed (2 cycles of extra input latency).

module edge_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic sig_s;
    logic sig_prev_r;

`ifdef FREQ_METER_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-stage synchronizer for a possibly asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
        end
    end

    assign sig_s = sync2_r;
`else
    assign sig_s = sig_in;
`endif

    // Previous-cycle copy of the (possibly synchronized) input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_prev_r <= 1'b0;
        end else begin
            sig_prev_r <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_prev_r;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of a clk-synchronous divided signal over a
// fixed window of GATE_CYCLES clk cycles and reports the saturating count.
// Optional feature macro: FREQ_METER_SYNC_EN (input synchronizer, see
// edge_rise_det). Handshake timing is the same with or without it.

module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 256,
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    freq_meter_if.slave  bus
);

    localparam logic [CNT_W-1:0]  ACC_MAX   = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    generate
        if (!(`FREQ_METER_GATE_W_FITS(GATE_CYCLES, GATE_W))) begin : g_gate_w_bad
            $error("freq_meter: GATE_CYCLES must be >= 1 and < 2**GATE_W");
        end
    endgenerate

    state_t            state_r;
    logic [GATE_W-1:0] gate_r;
    logic [CNT_W-1:0]  acc_r;
    logic              ovf_r;
    logic              busy_r;
    logic              done_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              rise_s;

    edge_rise_det u_edge_rise_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise_s)
    );

    // Measurement FSM with gate down-counter, saturating accumulator and
    // registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gate_r     <= {GATE_W{1'b0}};
            acc_r      <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // busy stays high through the done cycle and drops here
                    // unless a back-to-back start is accepted.
                    done_r <= 1'b0;
                    busy_r <= bus.start;
                    if (bus.start) begin
                        state_r <= ST_ARM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    // A rise during this cycle is deliberately ignored.
                    acc_r   <= {CNT_W{1'b0}};
                    ovf_r   <= 1'b0;
                    gate_r  <= GATE_LOAD;
                    state_r <= ST_MEAS;
                end
                ST_MEAS: begin
                    if (rise_s) begin
                        if (acc_r == ACC_MAX) begin
                            ovf_r <= 1'b1;
                        end else begin
                            acc_r <= acc_r + CNT_W'(1);
                        end
                    end
                    // The rise in the gate==0 cycle is still counted above.
                    if (gate_r == {GATE_W{1'b0}}) begin
                        state_r <= ST_DONE;
                    end else begin
                        gate_r  <= gate_r - GATE_W'(1);
                        state_r <= ST_MEAS;
                    end
                end
                ST_DONE: begin
                    count_r    <= acc_r;
                    overflow_r <= ovf_r;
                    done_r     <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.edge_count = count_r;
    assign bus.overflow   = overflow_r;

endmodule
